// File: rtl/seq_counter_pkg.sv
// -----------------------------------------------------------------------------
// seq_counter_pkg
//
// Shared constants for the programmable sequence counter:
//   - counting mode encodings (2-bit, as presented on the MODE input)
//   - ping-pong direction encodings (as presented on the DIR output)
//
// No ports; imported by seq_step_next and seq_step_counter.
// -----------------------------------------------------------------------------
package seq_counter_pkg;

    // Counting modes.
    localparam logic [1:0] MODE_UP_WRAP   = 2'd0;
    localparam logic [1:0] MODE_DOWN_WRAP = 2'd1;
    localparam logic [1:0] MODE_SAT_UP    = 2'd2;
    localparam logic [1:0] MODE_PINGPONG  = 2'd3;

    // Ping-pong direction.
    localparam logic DIR_UP = 1'b0;
    localparam logic DIR_DN = 1'b1;

endpackage : seq_counter_pkg

// File: rtl/seq_step_next.sv
// -----------------------------------------------------------------------------
// seq_step_next
//
// Purely combinational next-state function of the sequence counter. Given the
// current count and direction plus the runtime mode/step/limit, it computes
// the count and direction one enabled step later and whether that step is a
// terminal-count event.
//
// Ports
//   cnt_i       in   WIDTH    current count
//   dir_i       in   1        current ping-pong direction (0=up, 1=down)
//   mode_i      in   2        counting mode (see seq_counter_pkg)
//   step_i      in   STEP_W   step amount, zero-extended
//   limit_i     in   WIDTH    top of range, range is [0, limit_i]
//   cnt_next_o  out  WIDTH    count after one enabled step
//   dir_next_o  out  1        direction after one enabled step
//   tc_hit_o    out  1        the step is a terminal-count event
// -----------------------------------------------------------------------------
module seq_step_next
    import seq_counter_pkg::*;
#(
    parameter int WIDTH  = 32,
    parameter int STEP_W = 8
) (
    input  logic [WIDTH-1:0]  cnt_i,
    input  logic              dir_i,
    input  logic [1:0]        mode_i,
    input  logic [STEP_W-1:0] step_i,
    input  logic [WIDTH-1:0]  limit_i,
    output logic [WIDTH-1:0]  cnt_next_o,
    output logic              dir_next_o,
    output logic              tc_hit_o
);

    // All sums and compares are one bit wider than the counter so that
    // CNT+STEP near the top of the range cannot silently wrap.
    logic [WIDTH:0]   cnt_w;
    logic [WIDTH:0]   lim_w;
    logic [WIDTH:0]   step_w;
    logic [WIDTH:0]   sum_w;
    logic [WIDTH-1:0] diff;
    logic             above_lim;

    assign cnt_w     = {1'b0, cnt_i};
    assign lim_w     = {1'b0, limit_i};
    assign step_w    = {{(WIDTH + 1 - STEP_W){1'b0}}, step_i};
    assign sum_w     = cnt_w + step_w;
    // Only selected when CNT >= STEP, so the narrow subtraction never wraps.
    assign diff      = cnt_i - step_w[WIDTH-1:0];
    // LIMIT may have been lowered underneath a running count.
    assign above_lim = (cnt_w > lim_w);

    always_comb begin
        // NOTE: every output gets a default before the case so that no path
        // leaves it unassigned, which would otherwise infer a latch.
        cnt_next_o = cnt_i;
        dir_next_o = dir_i;
        tc_hit_o   = 1'b0;

        unique case (mode_i)
            MODE_UP_WRAP: begin
                // Also covers CNT above a lowered LIMIT: CNT+S > LIMIT holds.
                if (sum_w > lim_w) begin
                    cnt_next_o = '0;
                    tc_hit_o   = 1'b1;
                end else begin
                    cnt_next_o = sum_w[WIDTH-1:0];
                end
            end

            MODE_DOWN_WRAP: begin
                if (above_lim || (cnt_w < step_w)) begin
                    cnt_next_o = limit_i;
                    tc_hit_o   = 1'b1;
                end else begin
                    cnt_next_o = diff;
                end
            end

            MODE_SAT_UP: begin
                if (above_lim) begin
                    // Pulled back into range without counting as an arrival.
                    cnt_next_o = limit_i;
                end else if (cnt_w == lim_w) begin
                    cnt_next_o = cnt_i;
                end else if (sum_w >= lim_w) begin
                    cnt_next_o = limit_i;
                    tc_hit_o   = 1'b1;
                end else begin
                    cnt_next_o = sum_w[WIDTH-1:0];
                end
            end

            MODE_PINGPONG: begin
                if (above_lim) begin
                    cnt_next_o = limit_i;
                    dir_next_o = DIR_DN;
                    tc_hit_o   = 1'b1;
                end else if (dir_i == DIR_UP) begin
                    // >= (not >) so a zero step still turns at the top.
                    if (sum_w >= lim_w) begin
                        cnt_next_o = limit_i;
                        dir_next_o = DIR_DN;
                        tc_hit_o   = 1'b1;
                    end else begin
                        cnt_next_o = sum_w[WIDTH-1:0];
                    end
                end else begin
                    // <= (not <) so a zero step still turns at the bottom.
                    if (cnt_w <= step_w) begin
                        cnt_next_o = '0;
                        dir_next_o = DIR_UP;
                        tc_hit_o   = 1'b1;
                    end else begin
                        cnt_next_o = diff;
                    end
                end
            end

            default: begin
                cnt_next_o = cnt_i;
            end
        endcase
    end

endmodule : seq_step_next

// File: rtl/seq_step_counter.sv
// -----------------------------------------------------------------------------
// seq_step_counter
//
// Programmable sequence counter with runtime step, limit and mode (up-wrap,
// down-wrap, saturate-up, ping-pong). Produces a registered one-cycle
// terminal-count pulse and a wrapping tally of those pulses. Used as a
// timebase, address walker or phase generator next to control logic.
//
// Priority each cycle: reset > load > enable. With neither load nor enable
// all state holds and the terminal-count pulse drops.
//
// Ports
//   clk_i       in   1        clock, all state on rising edge
//   rst_n_i     in   1        synchronous reset, active-low
//   en_i        in   1        advance one step this cycle
//   mode_i      in   2        0=UP_WRAP 1=DOWN_WRAP 2=SAT_UP 3=PINGPONG
//   step_i      in   STEP_W   step amount, zero-extended
//   limit_i     in   WIDTH    top of range, range is [0, limit_i]
//   load_i      in   1        load count from load_val_i
//   load_val_i  in   WIDTH    load value, clamped to limit_i
//   cnt_o       out  WIDTH    current count
//   dir_o       out  1        ping-pong direction, 0=up 1=down
//   tc_o        out  1        terminal-count pulse, one cycle
//   evt_cnt_o   out  EVT_W    number of terminal-count pulses, wraps
// -----------------------------------------------------------------------------
module seq_step_counter
    import seq_counter_pkg::*;
#(
    parameter int               WIDTH  = 32,
    parameter int               STEP_W = 8,
    parameter int               EVT_W  = 16,
    parameter logic [WIDTH-1:0] INIT   = '0
) (
    input  logic              clk_i,
    input  logic              rst_n_i,
    input  logic              en_i,
    input  logic [1:0]        mode_i,
    input  logic [STEP_W-1:0] step_i,
    input  logic [WIDTH-1:0]  limit_i,
    input  logic              load_i,
    input  logic [WIDTH-1:0]  load_val_i,
    output logic [WIDTH-1:0]  cnt_o,
    output logic              dir_o,
    output logic              tc_o,
    output logic [EVT_W-1:0]  evt_cnt_o
);

    logic [WIDTH-1:0] cnt_q,  cnt_d;
    logic             dir_q,  dir_d;
    logic             tc_q,   tc_d;
    logic [EVT_W-1:0] evt_q,  evt_d;

    logic [WIDTH-1:0] step_cnt;
    logic             step_dir;
    logic             step_tc;
    logic [WIDTH-1:0] load_clamped;

    seq_step_next #(
        .WIDTH  (WIDTH),
        .STEP_W (STEP_W)
    ) u_next (
        .cnt_i      (cnt_q),
        .dir_i      (dir_q),
        .mode_i     (mode_i),
        .step_i     (step_i),
        .limit_i    (limit_i),
        .cnt_next_o (step_cnt),
        .dir_next_o (step_dir),
        .tc_hit_o   (step_tc)
    );

    // A load never places the count outside the current range.
    assign load_clamped = (load_val_i > limit_i) ? limit_i : load_val_i;

    always_comb begin
        cnt_d = cnt_q;
        dir_d = dir_q;
        tc_d  = 1'b0;
        evt_d = evt_q;

        if (load_i) begin
            cnt_d = load_clamped;
            dir_d = DIR_UP;
        end else if (en_i) begin
            cnt_d = step_cnt;
            dir_d = step_dir;
            tc_d  = step_tc;
        end

        // The tally advances on the same edge that raises the pulse.
        if (tc_d) begin
            evt_d = evt_q + EVT_W'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        // NOTE: reset is sampled on the clock edge only, so it sits inside the
        // edge-triggered branch rather than in the sensitivity list.
        if (!rst_n_i) begin
            cnt_q <= INIT;
            dir_q <= DIR_UP;
            tc_q  <= 1'b0;
            evt_q <= '0;
        end else begin
            // NOTE: state registers use non-blocking assignment so every
            // register samples its pre-edge value regardless of statement order.
            cnt_q <= cnt_d;
            dir_q <= dir_d;
            tc_q  <= tc_d;
            evt_q <= evt_d;
        end
    end

    assign cnt_o     = cnt_q;
    assign dir_o     = dir_q;
    assign tc_o      = tc_q;
    assign evt_cnt_o = evt_q;

endmodule : seq_step_counter

// File: tb/tb_seq_step_counter.sv
// -----------------------------------------------------------------------------
// tb_seq_step_counter
//
// Directed bench for seq_step_counter with INIT=5. Inputs change 1 ns after a
// rising edge; outputs are checked at that same point, i.e. showing the state
// written by the edge just passed. All expected values are hand-computed.
// -----------------------------------------------------------------------------
module tb_seq_step_counter;

    localparam int               WIDTH  = 32;
    localparam int               STEP_W = 8;
    localparam int               EVT_W  = 16;
    localparam logic [WIDTH-1:0] INIT   = 32'd5;

    localparam logic [1:0] M_UP   = 2'd0;
    localparam logic [1:0] M_DOWN = 2'd1;
    localparam logic [1:0] M_SAT  = 2'd2;
    localparam logic [1:0] M_PP   = 2'd3;

    logic              clk;
    logic              rst_n;
    logic              en;
    logic [1:0]        mode;
    logic [STEP_W-1:0] step;
    logic [WIDTH-1:0]  limit;
    logic              load;
    logic [WIDTH-1:0]  load_val;
    logic [WIDTH-1:0]  cnt;
    logic              dir;
    logic              tc;
    logic [EVT_W-1:0]  evt_cnt;

    int n_checks = 0;
    int n_errors = 0;

    seq_step_counter #(
        .WIDTH  (WIDTH),
        .STEP_W (STEP_W),
        .EVT_W  (EVT_W),
        .INIT   (INIT)
    ) dut (
        .clk_i      (clk),
        .rst_n_i    (rst_n),
        .en_i       (en),
        .mode_i     (mode),
        .step_i     (step),
        .limit_i    (limit),
        .load_i     (load),
        .load_val_i (load_val),
        .cnt_o      (cnt),
        .dir_o      (dir),
        .tc_o       (tc),
        .evt_cnt_o  (evt_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] actual,
                         input logic [63:0] expected);
        n_checks++;
        if (actual !== expected) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, actual, expected);
        end
    endtask

    // Advance one clock and land 1 ns after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_state(input string tag, input logic [WIDTH-1:0] e_cnt,
                                input logic e_dir, input logic e_tc,
                                input logic [EVT_W-1:0] e_evt);
        check({tag, ".cnt"}, 64'(cnt), 64'(e_cnt));
        check({tag, ".dir"}, 64'(dir), 64'(e_dir));
        check({tag, ".tc"},  64'(tc),  64'(e_tc));
        check({tag, ".evt"}, 64'(evt_cnt), 64'(e_evt));
    endtask

    // One load cycle (enable may be set by the caller before calling).
    task automatic do_load(input logic [WIDTH-1:0] val);
        load     = 1'b1;
        load_val = val;
        tick();
        load     = 1'b0;
    endtask

    // Enabled-step stimulus table entries.
    typedef struct {
        logic [WIDTH-1:0] cnt;
        logic             dir;
        logic             tc;
        logic [EVT_W-1:0] evt;
    } exp_t;

    task automatic run_steps(input string tag, input exp_t exp_q[$]);
        en = 1'b1;
        foreach (exp_q[i]) begin
            tick();
            expect_state($sformatf("%s[%0d]", tag, i), exp_q[i].cnt,
                         exp_q[i].dir, exp_q[i].tc, exp_q[i].evt);
        end
        en = 1'b0;
    endtask

    initial begin
        exp_t q[$];

        rst_n    = 1'b0;
        en       = 1'b0;
        mode     = M_UP;
        step     = '0;
        limit    = 32'd10;
        load     = 1'b0;
        load_val = '0;

        // 1. Reset and hold.
        tick();
        tick();
        expect_state("reset", 5, 0, 0, 0);
        rst_n = 1'b1;
        for (int i = 0; i < 10; i++) tick();
        expect_state("hold10", 5, 0, 0, 0);

        // 2. UP_WRAP, LIMIT=10, STEP=3, from 0.
        mode = M_UP; limit = 32'd10; step = 8'd3;
        do_load(32'd0);
        expect_state("up.load", 0, 0, 0, 0);
        q = '{'{3, 0, 0, 0}, '{6, 0, 0, 0}, '{9, 0, 0, 0}, '{0, 0, 1, 1}};
        run_steps("up", q);
        tick();
        expect_state("up.idle", 0, 0, 0, 1);

        // 3. DOWN_WRAP, LIMIT=7, STEP=2, from 5.
        mode = M_DOWN; limit = 32'd7; step = 8'd2;
        do_load(32'd5);
        expect_state("dn.load", 5, 0, 0, 1);
        q = '{'{3, 0, 0, 1}, '{1, 0, 0, 1}, '{7, 0, 1, 2}, '{5, 0, 0, 2}};
        run_steps("dn", q);

        // 4. PINGPONG, LIMIT=6, STEP=4, from 0.
        mode = M_PP; limit = 32'd6; step = 8'd4;
        do_load(32'd0);
        expect_state("pp.load", 0, 0, 0, 2);
        q = '{'{4, 0, 0, 2}, '{6, 1, 1, 3}, '{2, 1, 0, 3},
              '{0, 0, 1, 4}, '{4, 0, 0, 4}};
        run_steps("pp", q);

        // 5. SAT_UP, LIMIT=9, STEP=4, from 0, then five more enables at top.
        mode = M_SAT; limit = 32'd9; step = 8'd4;
        do_load(32'd0);
        q = '{'{4, 0, 0, 4}, '{8, 0, 0, 4}, '{9, 0, 1, 5}, '{9, 0, 0, 5},
              '{9, 0, 0, 5}, '{9, 0, 0, 5}, '{9, 0, 0, 5}, '{9, 0, 0, 5}};
        run_steps("sat", q);

        // 6a. Load clamped to LIMIT.
        mode = M_UP; limit = 32'd20; step = 8'd3;
        do_load(32'd100);
        expect_state("clamp", 20, 0, 0, 5);

        // 6b. Load and enable together: load wins, no step, no pulse.
        en = 1'b1;
        do_load(32'd7);
        en = 1'b0;
        expect_state("load_en", 7, 0, 0, 5);

        // 6c. LIMIT lowered under the count, per mode.
        do_load(32'd8);
        limit = 32'd3;
        q = '{'{0, 0, 1, 6}};
        run_steps("low.up", q);

        mode = M_DOWN; limit = 32'd20;
        do_load(32'd8);
        limit = 32'd3;
        q = '{'{3, 0, 1, 7}};
        run_steps("low.dn", q);

        mode = M_SAT; limit = 32'd20;
        do_load(32'd8);
        limit = 32'd3;
        q = '{'{3, 0, 0, 7}};
        run_steps("low.sat", q);

        mode = M_PP; limit = 32'd20;
        do_load(32'd8);
        limit = 32'd3;
        q = '{'{3, 1, 1, 8}};
        run_steps("low.pp", q);

        // 6d. LIMIT=0 pins the count at 0 and pulses on every enable.
        mode = M_UP; limit = 32'd0; step = 8'd1;
        do_load(32'd0);
        q = '{'{0, 0, 1, 9}};
        run_steps("lim0.up", q);
        mode = M_PP;
        q = '{'{0, 1, 1, 10}, '{0, 0, 1, 11}};
        run_steps("lim0.pp", q);

        // 6e. STEP=0: ping-pong still turns at the top; up-wrap holds, DIR kept.
        mode = M_PP; limit = 32'd6; step = 8'd0;
        do_load(32'd6);
        q = '{'{6, 1, 1, 12}, '{6, 1, 0, 12}};
        run_steps("step0.pp", q);
        mode = M_UP;
        q = '{'{6, 1, 0, 12}};
        run_steps("step0.up", q);

        // 6f. Reset mid-count overrides load and enable.
        mode = M_UP; limit = 32'd50; step = 8'd2;
        do_load(32'd10);
        q = '{'{12, 0, 0, 12}, '{14, 0, 0, 12}};
        run_steps("pre_rst", q);
        rst_n = 1'b0; en = 1'b1; load = 1'b1; load_val = 32'd40;
        tick();
        expect_state("mid_rst", 5, 0, 0, 0);
        rst_n = 1'b1; en = 1'b0; load = 1'b0;
        tick();
        expect_state("post_rst", 5, 0, 0, 0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule : tb_seq_step_counter
